ex_operand_stage: RTL and testbench
===================================

EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 Parameter WORD_W, default 32, width of data operands and results.
REQ-002 Parameter OP_W, default 4, width of the ALU operation code (cpu_types_pkg ALU op encoding).
REQ-003 CLK  in  1  single clock; all state updates on the rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 id_valid  in  1  decode presents a valid instruction.
REQ-006 id_rs1, id_rs2  in  5 each  source register indices.
REQ-007 id_rs1_data, id_rs2_data  in  WORD_W each  register-file read data.
REQ-008 id_imm  in  WORD_W  sign-extended immediate.
REQ-009 id_use_imm  in  1  operand B is id_imm, not rs2.
REQ-010 id_op  in  OP_W  ALU operation.
REQ-011 id_rd, id_regwrite, id_is_load  in  5/1/1  destination, write enable, load flag.
REQ-012 mem_wen, mem_rd, mem_data  in  1/5/WORD_W  EX/MEM stage write-back candidate.
REQ-013 wb_wen, wb_rd, wb_data  in  1/5/WORD_W  MEM/WB stage write-back candidate.
REQ-014 stall  in  1  downstream hold request.
REQ-015 flush  in  1  kill the held and incoming instruction.
REQ-016 alu_a, alu_b  out  WORD_W each  registered ALU operands.
REQ-017 alu_op  out  OP_W  registered ALU operation.
REQ-018 ex_valid, ex_rd, ex_regwrite, ex_is_load  out  1/5/1/1  registered control for the EX stage.
REQ-019 load_use_hazard  out  1  combinational; upstream holds decode while high.

Function
REQ-020 Forward resolution for a source index s with register-file data d: if s==0 then 0; else if mem_wen and mem_rd==s then mem_data; else if wb_wen and wb_rd==s then wb_data; else d.
REQ-021 load_use_hazard = id_valid & ex_valid & ex_is_load & ex_rd!=0 & (ex_rd==id_rs1 | (ex_rd==id_rs2 & !id_use_imm)).
REQ-022 Priority per cycle: RST > flush > stall > load_use_hazard > capture.
REQ-023 flush (no RST): ex_valid<=0, ex_regwrite<=0, ex_is_load<=0; operand registers unchanged.
REQ-024 stall (no flush): all outputs hold, except held operands are refreshed per REQ-025.
REQ-025 Refresh while stalled: if ex_valid and the captured rs1 index is nonzero, alu_a takes the REQ-020 result using the current alu_a as d; alu_b is refreshed likewise only when the captured instruction did not use the immediate.
REQ-026 load_use_hazard (no stall/flush): insert a bubble: ex_valid<=0, ex_regwrite<=0, ex_is_load<=0.
REQ-027 Capture (none of the above): alu_a<=resolved rs1; alu_b<=id_use_imm ? id_imm : resolved rs2; alu_op, ex_rd, ex_is_load<=id fields; ex_valid<=id_valid; ex_regwrite<=id_valid & id_regwrite.
REQ-028 The stage internally holds captured rs1, rs2, and use_imm for REQ-025.
REQ-029 Latency: exactly one cycle from capture to alu_a/alu_b/alu_op; no combinational path from id_* data to alu_*.
REQ-030 id_valid=0 at capture: ex_valid=0 and ex_regwrite=0; operand values are don't-care but are still registered.
REQ-031 mem_wen and wb_wen both match the same index: mem_data wins.
REQ-032 Writes to register 0 are never forwarded, regardless of mem_wen or wb_wen.

Reset
REQ-033 RST high at an edge: alu_a=0, alu_b=0, alu_op=0, ex_valid=0, ex_rd=0, ex_regwrite=0, ex_is_load=0, and internal rs1/rs2/use_imm=0; this overrides stall and flush.
REQ-034 RST asserted mid-stall discards the held instruction; the first capture after RST deasserts follows REQ-027.

Verification
REQ-035 Capture: rs1=3 (data 0x10), rs2=4 (data 0x20), no forwards -> next cycle alu_a=0x10, alu_b=0x20, ex_valid=1.
REQ-036 Forwarding priority: rs1=5, mem_rd=5/0xAAAA, wb_rd=5/0xBBBB, both wen -> alu_a=0xAAAA; rs2=0 with mem_rd=0/0xFFFF -> alu_b=0.
REQ-037 Load-use: EX holds a load with rd=7; ID rs1=7 -> load_use_hazard=1, next cycle ex_valid=0; on the following cycle capture forwards mem_data.
REQ-038 Stall refresh: hold an instruction with rs2=9 under stall, present wb_wen=1, wb_rd=9, wb_data=0x55 -> alu_b=0x55 while ex_valid stays 1 and alu_op is unchanged.
REQ-039 Priorities: stall and flush together -> ex_valid=0; RST together with flush and stall -> all outputs 0 on the next cycle.
REQ-040 Immediate: id_use_imm=1, imm=0xFFFFFFFC, rs2 matching mem_rd -> alu_b=0xFFFFFFFC, and no refresh of alu_b during a later stall.

Source files
------------

// File: rtl/ex_operand_stage.sv
// EX-stage operand register: resolves rs1/rs2 through EX/MEM and MEM/WB forwarding,
// detects load-use hazards, and keeps held operands fresh while the stage is stalled.
module ex_operand_stage #(
   parameter int WORD_W = 32,
   parameter int OP_W   = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              id_valid,
   input  logic [4:0]        id_rs1,
   input  logic [4:0]        id_rs2,
   input  logic [WORD_W-1:0] id_rs1_data,
   input  logic [WORD_W-1:0] id_rs2_data,
   input  logic [WORD_W-1:0] id_imm,
   input  logic              id_use_imm,
   input  logic [OP_W-1:0]   id_op,
   input  logic [4:0]        id_rd,
   input  logic              id_regwrite,
   input  logic              id_is_load,
   input  logic              mem_wen,
   input  logic [4:0]        mem_rd,
   input  logic [WORD_W-1:0] mem_data,
   input  logic              wb_wen,
   input  logic [4:0]        wb_rd,
   input  logic [WORD_W-1:0] wb_data,
   input  logic              stall,
   input  logic              flush,
   output logic [WORD_W-1:0] alu_a,
   output logic [WORD_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_op,
   output logic              ex_valid,
   output logic [4:0]        ex_rd,
   output logic              ex_regwrite,
   output logic              ex_is_load,
   output logic              load_use_hazard
);

   logic [4:0]        rs1_q, rs2_q;
   logic              use_imm_q;
   logic [WORD_W-1:0] fwd_rs1, fwd_rs2, ref_a, ref_b;

   // EX/MEM is younger than MEM/WB, so it takes priority; x0 is hard-wired zero.
   function automatic logic [WORD_W-1:0] resolve(
      input logic [4:0]        s,
      input logic [WORD_W-1:0] d,
      input logic              mw,
      input logic [4:0]        mr,
      input logic [WORD_W-1:0] md,
      input logic              ww,
      input logic [4:0]        wr,
      input logic [WORD_W-1:0] wd
   );
      if (s == 5'd0)            return '0;
      else if (mw && mr == s)   return md;
      else if (ww && wr == s)   return wd;
      else                      return d;
   endfunction

   always_comb begin
      fwd_rs1 = resolve(id_rs1, id_rs1_data, mem_wen, mem_rd, mem_data, wb_wen, wb_rd, wb_data);
      fwd_rs2 = resolve(id_rs2, id_rs2_data, mem_wen, mem_rd, mem_data, wb_wen, wb_rd, wb_data);
      ref_a   = resolve(rs1_q, alu_a, mem_wen, mem_rd, mem_data, wb_wen, wb_rd, wb_data);
      ref_b   = resolve(rs2_q, alu_b, mem_wen, mem_rd, mem_data, wb_wen, wb_rd, wb_data);
   end

   assign load_use_hazard = id_valid & ex_valid & ex_is_load & (ex_rd != 5'd0) &
                            ((ex_rd == id_rs1) | ((ex_rd == id_rs2) & ~id_use_imm));

   always_ff @(posedge CLK) begin
      if (RST) begin
         alu_a       <= '0;
         alu_b       <= '0;
         alu_op      <= '0;
         ex_valid    <= 1'b0;
         ex_rd       <= '0;
         ex_regwrite <= 1'b0;
         ex_is_load  <= 1'b0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         use_imm_q   <= 1'b0;
      end else if (flush) begin
         ex_valid    <= 1'b0;
         ex_regwrite <= 1'b0;
         ex_is_load  <= 1'b0;
      end else if (stall) begin
         // Producers may retire while we wait; pick up their results so the held
         // operands are not stale when the stall releases.
         if (ex_valid && rs1_q != 5'd0)
            alu_a <= ref_a;
         if (ex_valid && !use_imm_q && rs2_q != 5'd0)
            alu_b <= ref_b;
      end else if (load_use_hazard) begin
         ex_valid    <= 1'b0;
         ex_regwrite <= 1'b0;
         ex_is_load  <= 1'b0;
      end else begin
         alu_a       <= fwd_rs1;
         alu_b       <= id_use_imm ? id_imm : fwd_rs2;
         alu_op      <= id_op;
         ex_rd       <= id_rd;
         ex_is_load  <= id_is_load;
         ex_valid    <= id_valid;
         ex_regwrite <= id_valid & id_regwrite;
         rs1_q       <= id_rs1;
         rs2_q       <= id_rs2;
         use_imm_q   <= id_use_imm;
      end
   end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: table of single-cycle captures plus
// hand-written stall, flush, load-use and reset sequences.
module tb_ex_operand_stage;

   logic        CLK = 1'b0;
   logic        RST;
   logic        id_valid, id_use_imm, id_regwrite, id_is_load;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [31:0] id_rs1_data, id_rs2_data, id_imm;
   logic [3:0]  id_op;
   logic        mem_wen, wb_wen, stall, flush;
   logic [4:0]  mem_rd, wb_rd;
   logic [31:0] mem_data, wb_data;
   logic [31:0] alu_a, alu_b;
   logic [3:0]  alu_op;
   logic        ex_valid, ex_regwrite, ex_is_load, load_use_hazard;
   logic [4:0]  ex_rd;

   int n_cmp = 0;
   int n_bad = 0;

   ex_operand_stage #(.WORD_W(32), .OP_W(4)) dut (
      .CLK(CLK), .RST(RST),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_imm(id_imm), .id_use_imm(id_use_imm), .id_op(id_op),
      .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
      .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_data(mem_data),
      .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
      .stall(stall), .flush(flush),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
      .ex_is_load(ex_is_load), .load_use_hazard(load_use_hazard)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic        valid;
      logic [4:0]  rs1, rs2;
      logic [31:0] d1, d2, imm;
      logic        use_imm;
      logic [3:0]  op;
      logic [4:0]  rd;
      logic        regwrite;
      logic        mw;
      logic [4:0]  mr;
      logic [31:0] md;
      logic        ww;
      logic [4:0]  wr;
      logic [31:0] wd;
      logic        chk_ops;
      logic [31:0] exp_a, exp_b;
      logic        exp_valid, exp_rw;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic idle();
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_data = 0; id_rs2_data = 0;
      id_imm = 0; id_use_imm = 0; id_op = 0; id_rd = 0; id_regwrite = 0; id_is_load = 0;
      mem_wen = 0; mem_rd = 0; mem_data = 0; wb_wen = 0; wb_rd = 0; wb_data = 0;
      stall = 0; flush = 0;
   endtask

   task automatic step();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic issue(input logic [4:0] rs1, input logic [31:0] d1,
                        input logic [4:0] rs2, input logic [31:0] d2,
                        input logic [3:0] op, input logic [4:0] rd, input logic ld);
      id_valid = 1; id_rs1 = rs1; id_rs1_data = d1; id_rs2 = rs2; id_rs2_data = d2;
      id_op = op; id_rd = rd; id_regwrite = 1; id_is_load = ld; id_use_imm = 0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " alu_a"}, alu_a, 0);
      chk({tag, " alu_b"}, alu_b, 0);
      chk({tag, " alu_op"}, 32'(alu_op), 0);
      chk({tag, " ex_valid"}, 32'(ex_valid), 0);
      chk({tag, " ex_rd"}, 32'(ex_rd), 0);
      chk({tag, " ex_regwrite"}, 32'(ex_regwrite), 0);
      chk({tag, " ex_is_load"}, 32'(ex_is_load), 0);
   endtask

   initial begin
      vec_t v;
      idle();
      RST = 1;

      // plain capture, no forwards
      v = '0; v.valid = 1; v.rs1 = 3; v.d1 = 32'h10; v.rs2 = 4; v.d2 = 32'h20; v.op = 2; v.rd = 1;
      v.regwrite = 1; v.chk_ops = 1; v.exp_a = 32'h10; v.exp_b = 32'h20; v.exp_valid = 1; v.exp_rw = 1;
      vecs.push_back(v);
      // mem beats wb on the same index
      v = '0; v.valid = 1; v.rs1 = 5; v.d1 = 32'h1; v.rs2 = 6; v.d2 = 32'h66; v.op = 3; v.rd = 2;
      v.regwrite = 1; v.mw = 1; v.mr = 5; v.md = 32'hAAAA; v.ww = 1; v.wr = 5; v.wd = 32'hBBBB;
      v.chk_ops = 1; v.exp_a = 32'hAAAA; v.exp_b = 32'h66; v.exp_valid = 1; v.exp_rw = 1;
      vecs.push_back(v);
      // x0 reads zero even when both stages claim to write it
      v = '0; v.valid = 1; v.rs1 = 0; v.d1 = 32'h77; v.rs2 = 0; v.d2 = 32'h99; v.op = 4; v.rd = 3;
      v.regwrite = 1; v.mw = 1; v.mr = 0; v.md = 32'hFFFF; v.ww = 1; v.wr = 0; v.wd = 32'hEEEE;
      v.chk_ops = 1; v.exp_a = 0; v.exp_b = 0; v.exp_valid = 1; v.exp_rw = 1;
      vecs.push_back(v);
      // wb forwards rs1, mem forwards rs2
      v = '0; v.valid = 1; v.rs1 = 8; v.d1 = 32'h1; v.rs2 = 9; v.d2 = 32'h2; v.op = 5; v.rd = 4;
      v.regwrite = 1; v.mw = 1; v.mr = 9; v.md = 32'h1111; v.ww = 1; v.wr = 8; v.wd = 32'hCAFE;
      v.chk_ops = 1; v.exp_a = 32'hCAFE; v.exp_b = 32'h1111; v.exp_valid = 1; v.exp_rw = 1;
      vecs.push_back(v);
      // matching indices without enables do not forward
      v = '0; v.valid = 1; v.rs1 = 10; v.d1 = 32'hA; v.rs2 = 11; v.d2 = 32'hB; v.op = 6; v.rd = 5;
      v.regwrite = 1; v.mr = 10; v.md = 32'hDEAD; v.wr = 11; v.wd = 32'hBEEF;
      v.chk_ops = 1; v.exp_a = 32'hA; v.exp_b = 32'hB; v.exp_valid = 1; v.exp_rw = 1;
      vecs.push_back(v);
      // immediate wins over a forwarded rs2
      v = '0; v.valid = 1; v.rs1 = 1; v.d1 = 32'h5; v.rs2 = 12; v.d2 = 32'h3; v.op = 7; v.rd = 6;
      v.regwrite = 1; v.use_imm = 1; v.imm = 32'hFFFFFFFC; v.mw = 1; v.mr = 12; v.md = 32'h1;
      v.chk_ops = 1; v.exp_a = 32'h5; v.exp_b = 32'hFFFFFFFC; v.exp_valid = 1; v.exp_rw = 1;
      vecs.push_back(v);
      // invalid slot: no valid, no regwrite
      v = '0; v.valid = 0; v.rs1 = 2; v.d1 = 32'h9; v.rs2 = 3; v.d2 = 32'h8; v.op = 8; v.rd = 7;
      v.regwrite = 1; v.chk_ops = 0; v.exp_valid = 0; v.exp_rw = 0;
      vecs.push_back(v);
      // valid without regwrite
      v = '0; v.valid = 1; v.rs1 = 2; v.d1 = 32'h12; v.rs2 = 3; v.d2 = 32'h13; v.op = 9; v.rd = 8;
      v.regwrite = 0; v.chk_ops = 1; v.exp_a = 32'h12; v.exp_b = 32'h13; v.exp_valid = 1; v.exp_rw = 0;
      vecs.push_back(v);

      @(negedge CLK);
      step();
      step();
      chk_zero("reset");
      RST = 0;

      foreach (vecs[i]) begin
         v = vecs[i];
         idle();
         id_valid = v.valid; id_rs1 = v.rs1; id_rs2 = v.rs2; id_rs1_data = v.d1;
         id_rs2_data = v.d2; id_imm = v.imm; id_use_imm = v.use_imm; id_op = v.op;
         id_rd = v.rd; id_regwrite = v.regwrite;
         mem_wen = v.mw; mem_rd = v.mr; mem_data = v.md;
         wb_wen = v.ww; wb_rd = v.wr; wb_data = v.wd;
         #1;
         chk($sformatf("vec%0d hazard", i), 32'(load_use_hazard), 0);
         step();
         if (v.chk_ops) begin
            chk($sformatf("vec%0d alu_a", i), alu_a, v.exp_a);
            chk($sformatf("vec%0d alu_b", i), alu_b, v.exp_b);
         end
         chk($sformatf("vec%0d alu_op", i), 32'(alu_op), 32'(v.op));
         chk($sformatf("vec%0d ex_rd", i), 32'(ex_rd), 32'(v.rd));
         chk($sformatf("vec%0d ex_valid", i), 32'(ex_valid), 32'(v.exp_valid));
         chk($sformatf("vec%0d ex_regwrite", i), 32'(ex_regwrite), 32'(v.exp_rw));
      end

      // load-use: load to x7 in EX
      idle(); issue(1, 32'h1, 2, 32'h2, 4'h1, 7, 1); step();
      chk("lu ex_is_load", 32'(ex_is_load), 1);
      idle(); id_valid = 1; id_rs1 = 3; id_rs2 = 7; id_use_imm = 1; #1;
      chk("lu imm masks rs2", 32'(load_use_hazard), 0);
      id_use_imm = 0; #1;
      chk("lu rs2 hazard", 32'(load_use_hazard), 1);
      idle(); issue(7, 32'h0, 3, 32'h33, 4'h2, 9, 0); #1;
      chk("lu rs1 hazard", 32'(load_use_hazard), 1);
      step();
      chk("lu bubble ex_valid", 32'(ex_valid), 0);
      chk("lu bubble regwrite", 32'(ex_regwrite), 0);
      chk("lu bubble is_load", 32'(ex_is_load), 0);
      mem_wen = 1; mem_rd = 7; mem_data = 32'h4242; #1;
      chk("lu released", 32'(load_use_hazard), 0);
      step();
      chk("lu fwd alu_a", alu_a, 32'h4242);
      chk("lu fwd alu_b", alu_b, 32'h33);
      chk("lu ex_valid", 32'(ex_valid), 1);

      // load to x0 never causes a hazard
      idle(); issue(1, 32'h1, 2, 32'h2, 4'h1, 0, 1); step();
      idle(); id_valid = 1; id_rs1 = 0; id_rs2 = 0; #1;
      chk("lu x0 no hazard", 32'(load_use_hazard), 0);

      // stall refresh of rs2 from wb
      idle(); issue(2, 32'h22, 9, 32'h99, 4'h5, 10, 0); step();
      idle(); issue(3, 32'h33, 4, 32'h44, 4'hC, 11, 0);
      stall = 1; wb_wen = 1; wb_rd = 9; wb_data = 32'h55; step();
      chk("stall alu_b refresh", alu_b, 32'h55);
      chk("stall alu_a held", alu_a, 32'h22);
      chk("stall ex_valid", 32'(ex_valid), 1);
      chk("stall alu_op", 32'(alu_op), 5);
      chk("stall ex_rd", 32'(ex_rd), 10);

      // immediate operand must not be refreshed under stall; rs1 still is
      idle(); issue(13, 32'h3, 12, 32'h4, 4'h7, 12, 0);
      id_use_imm = 1; id_imm = 32'hFFFFFFFC; step();
      chk("imm alu_b", alu_b, 32'hFFFFFFFC);
      idle(); stall = 1; mem_wen = 1; mem_rd = 12; mem_data = 32'h1234;
      wb_wen = 1; wb_rd = 13; wb_data = 32'h77; step();
      chk("imm stall alu_b", alu_b, 32'hFFFFFFFC);
      chk("imm stall alu_a", alu_a, 32'h77);

      // flush alone: control cleared, operands kept
      idle(); issue(14, 32'hAB, 15, 32'hCD, 4'h3, 14, 1); step();
      idle(); issue(1, 32'h1, 1, 32'h1, 4'h9, 1, 0); flush = 1; step();
      chk("flush ex_valid", 32'(ex_valid), 0);
      chk("flush is_load", 32'(ex_is_load), 0);
      chk("flush alu_a kept", alu_a, 32'hAB);
      chk("flush alu_op kept", 32'(alu_op), 3);

      // stall + flush: flush wins
      idle(); issue(14, 32'hAB, 15, 32'hCD, 4'h3, 14, 0); step();
      idle(); stall = 1; flush = 1; step();
      chk("stall+flush ex_valid", 32'(ex_valid), 0);
      chk("stall+flush regwrite", 32'(ex_regwrite), 0);

      // RST + flush + stall: everything zero
      idle(); issue(14, 32'hAB, 15, 32'hCD, 4'h3, 14, 1); step();
      idle(); stall = 1; flush = 1; RST = 1; step();
      chk_zero("rst+flush+stall");

      // RST mid-stall, then first capture after release
      RST = 0; idle(); issue(5, 32'h50, 6, 32'h60, 4'h4, 5, 0); step();
      idle(); stall = 1; step();
      RST = 1; step();
      chk_zero("rst mid-stall");
      RST = 0; idle(); issue(7, 32'h70, 8, 32'h80, 4'h6, 9, 0); step();
      chk("post-rst alu_a", alu_a, 32'h70);
      chk("post-rst alu_b", alu_b, 32'h80);
      chk("post-rst ex_valid", 32'(ex_valid), 1);
      chk("post-rst alu_op", 32'(alu_op), 6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
